// File: rtl/cacheline_adapter_pkg.sv
// Shared cache-line types for the rv32i memory hierarchy.
// Also carries the fixed geometry of the cacheline_adapter burst.
package rv32i_types;

    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_BURST,
        RESP
    } cacheline_adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit line request from the caches into a 4-beat, 64-bit burst
// on banked memory, then returns a single-cycle dfp_resp.
module cacheline_adapter
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_W-1:0]    dfp_wdata,
    output logic [LINE_W-1:0]    dfp_rdata,
    output logic                 dfp_resp,

    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_W-1:0]    bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_W-1:0]    bmem_rdata,
    input  logic                 bmem_rvalid
);

    cacheline_adapter_state_t state_reg, state_next;
    logic [1:0]  beat_reg, beat_next;
    logic [31:0] addr_reg, addr_next;
    logic        beat_accept;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^dfp_addr[OFFSET_W-1:0];

    // Beats tagged with another line's address belong to someone else; drop them.
    assign beat_accept = (state_reg == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        addr_next  = addr_reg;
        unique case (state_reg)
            IDLE: begin
                // Write wins when both requests are up.
                if (dfp_write && bmem_ready) begin
                    state_next = WR_BURST;
                    beat_next  = '0;
                    addr_next  = {dfp_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                end else if (dfp_read && bmem_ready) begin
                    state_next = RD_ISSUE;
                    addr_next  = {dfp_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            RD_ISSUE: begin
                state_next = RD_WAIT;
                beat_next  = '0;
            end
            RD_WAIT: begin
                if (beat_accept) begin
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == 2'(BEATS - 1)) state_next = RESP;
                end
            end
            WR_BURST: begin
                beat_next = beat_reg + 2'd1;
                if (beat_reg == 2'(BEATS - 1)) state_next = RESP;
            end
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Each beat lane keeps its last value until the next read refills it.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] rbeat_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rbeat_reg <= '0;
                end else if (beat_accept && (beat_reg == 2'(gi))) begin
                    rbeat_reg <= bmem_rdata;
                end
            end

            assign dfp_rdata[gi*BEAT_W +: BEAT_W] = rbeat_reg;
        end
    endgenerate

    assign bmem_addr  = addr_reg;
    assign bmem_read  = (state_reg == RD_ISSUE);
    assign bmem_write = (state_reg == WR_BURST);
    assign dfp_resp   = (state_reg == RESP);
    assign bmem_wdata = (state_reg == WR_BURST) ? dfp_wdata[beat_reg*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: line-level memory reference model,
// memory responder process and an independent output monitor.
module tb_cacheline_adapter;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata, dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr, bmem_raddr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    cacheline_adapter dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endfunction

    typedef struct { bit is_rd; logic [31:0] addr; logic [255:0] data; } resp_t;
    typedef struct { logic [31:0] addr; logic [63:0] data; } beat_t;

    resp_t        exp_resp_q[$];
    logic [31:0]  exp_rd_q[$];
    beat_t        exp_beat_q[$];
    logic [255:0] ref_mem  [bit [26:0]];
    logic [255:0] phys_mem [bit [26:0]];
    logic [255:0] last_line = '0;

    function automatic logic [255:0] init_line(bit [26:0] idx);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = {5'b10101, idx, 32'hC0DE_0000 + 32'(k)};
        return l;
    endfunction

    function automatic logic [255:0] ref_get(bit [26:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_line(idx);
    endfunction

    function automatic logic [255:0] phys_get(bit [26:0] idx);
        return phys_mem.exists(idx) ? phys_mem[idx] : init_line(idx);
    endfunction

    // Reference model: a line write stores the line and must appear as beats
    // 0..3 in order; a line read returns whatever the line currently holds.
    function automatic void model_write(logic [31:0] a, logic [255:0] d);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        ref_mem[a[31:5]] = d;
        for (int k = 0; k < 4; k++) exp_beat_q.push_back('{la, d[k*64 +: 64]});
        exp_resp_q.push_back('{1'b0, la, '0});
    endfunction

    function automatic void model_read(logic [31:0] a);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        exp_rd_q.push_back(la);
        last_line = ref_get(a[31:5]);
        exp_resp_q.push_back('{1'b1, la, last_line});
    endfunction

    // Memory responder
    int lat = 1;
    int spur = 0;
    bit gap_spur = 0;
    bit idle_spur = 0;

    initial begin
        logic [31:0]  a;
        logic [255:0] line;
        int           l;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bmem_read) begin
                a = bmem_addr;
                line = phys_get(a[31:5]);
                l = lat;
                for (int i = 1; i < l; i++) begin
                    @(negedge clk);
                    if (i <= spur) begin
                        bmem_rvalid = 1'b1; bmem_raddr = a ^ 32'h20; bmem_rdata = {$urandom, $urandom};
                    end else begin
                        bmem_rvalid = 1'b0;
                    end
                end
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    if (gap_spur && $urandom_range(0, 2) == 0) begin
                        bmem_rvalid = 1'b1; bmem_raddr = a ^ 32'h20; bmem_rdata = {$urandom, $urandom};
                        @(negedge clk);
                    end
                    bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = line[k*64 +: 64];
                    @(negedge clk);
                end
                bmem_rvalid = 1'b0;
            end else if (idle_spur) begin
                bmem_rvalid = 1'b1; bmem_raddr = $urandom & 32'hFFFF_FFE0; bmem_rdata = {$urandom, $urandom};
            end else begin
                bmem_rvalid = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        int wbeat = 0;
        beat_t b;
        resp_t r;
        logic [255:0] pl;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bmem_read) begin
                    if (exp_rd_q.size() == 0) fail_now("unexpected_bmem_read", $sformatf("got pulse addr %h expected none", bmem_addr));
                    else chk("bmem_read_addr", 256'(bmem_addr), 256'(exp_rd_q.pop_front()));
                end
                if (bmem_write) begin
                    if (exp_beat_q.size() == 0) begin
                        fail_now("unexpected_bmem_write", $sformatf("got beat %h expected none", bmem_wdata));
                    end else begin
                        b = exp_beat_q.pop_front();
                        chk("bmem_write_addr", 256'(bmem_addr), 256'(b.addr));
                        chk("bmem_wdata", 256'(bmem_wdata), 256'(b.data));
                    end
                    pl = phys_get(bmem_addr[31:5]);
                    pl[wbeat*64 +: 64] = bmem_wdata;
                    phys_mem[bmem_addr[31:5]] = pl;
                    wbeat = (wbeat + 1) % 4;
                end
                if (dfp_resp) begin
                    if (exp_resp_q.size() == 0) begin
                        fail_now("unexpected_dfp_resp", "got pulse expected none");
                    end else begin
                        r = exp_resp_q.pop_front();
                        if (r.is_rd) chk("dfp_rdata", dfp_rdata, r.data);
                        else chk("write_beats_done_at_resp", 256'(exp_beat_q.size()), 256'(0));
                    end
                end
            end
        end
    end

    task automatic wait_resp(output int at_cyc);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dfp_resp) begin
                at_cyc = cyc;
                return;
            end
        end
        fail_now("resp_timeout", "got no dfp_resp in 300 cycles expected one");
        at_cyc = -1;
    endtask

    task automatic do_xact(input bit wr, input logic [31:0] a, input logic [255:0] d,
                           input int l, input int hold, output int t_acc, output int t_resp);
        if (wr) model_write(a, d);
        else    model_read(a);
        lat = l;
        @(negedge clk);
        dfp_addr = a; dfp_wdata = d; dfp_write = wr; dfp_read = !wr;
        bmem_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("no_cmd_while_not_ready", 256'({bmem_read, bmem_write}), 256'(0));
        end
        bmem_ready = 1'b1;
        t_acc = cyc;
        wait_resp(t_resp);
        dfp_read = 1'b0;
        dfp_write = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_dfp_resp"},   256'(dfp_resp),   256'(0));
        chk({tag, "_bmem_read"},  256'(bmem_read),  256'(0));
        chk({tag, "_bmem_write"}, 256'(bmem_write), 256'(0));
        chk({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'(0));
        chk({tag, "_bmem_addr"},  256'(bmem_addr),  256'(0));
        chk({tag, "_dfp_rdata"},  dfp_rdata,        256'(0));
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ta, tr, tr2, t0;
        logic [255:0] d, prev;
        logic [31:0]  a;
        bit wr;
        rst = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0; bmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Directed read, L=3
        d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        ref_mem[27'(32'h1220 >> 5)] = d;
        phys_mem[27'(32'h1220 >> 5)] = d;
        do_xact(1'b0, 32'h0000_1234, '0, 3, 0, ta, tr);
        chk("read_resp_cycle", 256'(tr - ta), 256'(8));

        // Directed write
        d = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        do_xact(1'b1, 32'h0000_2047, d, 1, 0, ta, tr);
        chk("write_resp_cycle", 256'(tr - ta), 256'(5));

        // Backpressure: ready low for 5 cycles on a read of the line just written
        do_xact(1'b0, 32'h0000_2040, '0, 2, 5, ta, tr);
        chk("backpressure_resp_cycle", 256'(tr - ta), 256'(7));

        // Wrong-address beats before the real ones must not disturb dfp_rdata
        prev = last_line;
        model_read(32'h0000_1234);
        lat = 6; spur = 3;
        @(negedge clk);
        dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
        t0 = cyc;
        repeat (6) @(negedge clk);
        chk("rdata_hold_spurious", dfp_rdata, prev);
        wait_resp(tr);
        dfp_read = 1'b0;
        chk("spurious_resp_cycle", 256'(tr - t0), 256'(11));
        spur = 0;

        // rvalid while idle
        idle_spur = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_rvalid_no_resp", 256'(dfp_resp), 256'(0));
        end
        idle_spur = 1'b0;
        repeat (2) @(negedge clk);

        // Read and write together: write goes first, read follows
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        model_write(32'h0000_5000, d);
        model_read(32'h0000_5000);
        lat = 2;
        @(negedge clk);
        dfp_addr = 32'h0000_5000; dfp_wdata = d; dfp_write = 1'b1; dfp_read = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk("priority_write_first", 256'({bmem_write, bmem_read}), 256'(2'b10));
        wait_resp(tr);
        chk("priority_write_resp_cycle", 256'(tr - t0), 256'(5));
        dfp_write = 1'b0;
        wait_resp(tr2);
        dfp_read = 1'b0;

        // Randomized traffic over a few lines
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 32'd32 + 32'($urandom_range(0, 31));
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            gap_spur = 1'($urandom_range(0, 1));
            do_xact(wr, a, d, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), ta, tr);
            if (wr) chk("rand_write_resp_cycle", 256'(tr - ta), 256'(5));
        end
        gap_spur = 1'b0;

        // Reset after third beat of a read: no response, outputs cleared
        exp_rd_q.push_back(32'h0000_3000);
        lat = 1;
        @(negedge clk);
        dfp_addr = 32'h0000_3000; dfp_read = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        dfp_read = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midburst_reset");
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_no_resp", 256'(dfp_resp), 256'(0));
        end
        do_xact(1'b0, 32'h0000_3000, '0, 2, 0, ta, tr);
        chk("post_reset_read_resp_cycle", 256'(tr - ta), 256'(7));

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 256'(exp_resp_q.size() + exp_rd_q.size() + exp_beat_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the caches' 256-bit downward-facing port (`dfp_*`). It accepts one line read or write at a time and converts it into a 4-beat, 64-bit burst on the banked-memory interface (`bmem_*`). It then returns a single-cycle `dfp_resp` to the cache. It sits between `icache`/`dcache` (or their arbiter) and main memory.

## Interface
- No parameters. Line width is 256, beat width is 64, and beats per line is 4, all fixed by package constants.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, **active-low** reset (state cleared on a rising edge with `rst==0`).
- `dfp_addr`  in  32  line address; bits [4:0] ignored.
- `dfp_read`  in  1  line-read request, held by initiator until `dfp_resp`.
- `dfp_write`  in  1  line-write request, held until `dfp_resp`.
- `dfp_wdata`  in  256  write line; must be stable while `dfp_write` is held.
- `dfp_rdata`  out  256  read line; valid when `dfp_resp` is high after a read.
- `dfp_resp`  out  1  one-cycle completion pulse.
- `bmem_addr`  out  32  burst address, always `{dfp_addr[31:5],5'b0}`.
- `bmem_read`  out  1  one-cycle read-burst command.
- `bmem_write`  out  1  write beat strobe, high for 4 consecutive cycles.
- `bmem_wdata`  out  64  write beat data.
- `bmem_ready`  in  1  memory can accept a new command.
- `bmem_raddr`  in  32  address tag of the returning read beats.
- `bmem_rdata`  in  64  read beat data.
- `bmem_rvalid`  in  1  read beat valid.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP.
- **IDLE**
  - `dfp_write && bmem_ready` → WR_BURST with beat counter = 0 and address latched.
  - Else `dfp_read && bmem_ready` → RD_ISSUE with address latched.
  - Write has priority if both requests are high.
  - Without `bmem_ready`, stay in IDLE.
  - `bmem_rvalid` in IDLE is ignored.
- **RD_ISSUE**
  - `bmem_read=1` for exactly this one cycle, driving the latched address.
  - Then go to RD_WAIT with beat counter = 0.
- **RD_WAIT**
  - A beat is accepted on `bmem_rvalid && bmem_raddr == latched address`.
  - Beat k is written to `dfp_rdata[64k+63:64k]` and the counter increments.
  - Non-matching beats are dropped.
  - After beat 3 → RESP.
- **WR_BURST**
  - `bmem_write=1` every cycle, with `bmem_wdata = dfp_wdata[64k+63:64k]`, k = beat counter.
  - Beats never stall once started.
  - After k=3 → RESP.
- **RESP**
  - `dfp_resp=1` for one cycle, then IDLE.
  - The initiator deasserts its request in the cycle after `dfp_resp`.
  - A request still high in IDLE is treated as a new request.
- Beat counter is 2 bits and wraps to 0 on leaving a burst state.
- `dfp_rdata` holds its last assembled line until the next read's beat 0 overwrites it.

## Timing
- Reset values:
  - state = IDLE.
  - `dfp_resp`, `bmem_read`, `bmem_write` = 0.
  - `bmem_wdata` = 0, `dfp_rdata` = 0.
  - `bmem_addr` = 0 (latched address cleared).
- All outputs are registered-state decodes. There is no combinational path from `dfp_*` to `bmem_read`/`bmem_write`.
- Read, with the request accepted at cycle T:
  - `bmem_read` at T+1.
  - Beats arrive at memory latency L ≥ 1 after T+1.
  - `dfp_resp` in the cycle after the 4th accepted beat.
- Write, accepted at T:
  - Beats at T+1..T+4.
  - `dfp_resp` at T+5.
- Reset low mid-burst returns to IDLE on that edge. Remaining beats are discarded and no `dfp_resp` is produced.

## Structure
- Add to `rv32i_types`:
  - `cacheline_adapter_state_t` enum.
  - `LINE_W=256`, `BEAT_W=64`, `BEATS=4` localparams.
- Single flat module with no sub-modules. The 256-bit assembly register and beat counter are local.

## Test plan
- **Read burst:** `dfp_read`, `addr=0x0000_1234`, memory returns beats `0x11..1`, `0x22..2`, `0x33..3`, `0x44..4` with L=3.
  - `bmem_addr=0x0000_1220`.
  - Single `bmem_read` pulse.
  - `dfp_resp` one cycle after beat 4.
  - `dfp_rdata={0x44..4,0x33..3,0x22..2,0x11..1}`.
- **Write burst:** `dfp_write`, `wdata={D3,D2,D1,D0}`.
  - `bmem_write` high for 4 cycles with D0, D1, D2, D3 in order.
  - `dfp_resp` at T+5.
  - `bmem_read` never high.
- **Backpressure:** `bmem_ready=0` for 5 cycles while `dfp_read` is held.
  - No `bmem_read` until ready rises.
  - Completes normally afterwards.
- **Spurious data:**
  - `bmem_rvalid` with wrong `bmem_raddr` during RD_WAIT is ignored and `dfp_rdata` is unchanged.
  - `bmem_rvalid` in IDLE produces no `dfp_resp`.
- **Priority:** `dfp_read` and `dfp_write` both high in IDLE → write burst first.
- **Reset:** assert `rst=0` after beat 2 of a read. The next cycle shows IDLE with all outputs at reset values, and a following read completes correctly.
